// File: rtl/mouse_ps2_pkg.sv
// Shared PS/2 mouse definitions: FSM state encoding, error codes, frame sizes.
package mouse_ps2_pkg;

    typedef enum logic [1:0] {
        PS2_IDLE   = 2'd0,
        PS2_DATA   = 2'd1,
        PS2_PARITY = 2'd2,
        PS2_STOP   = 2'd3
    } ps2_state_e;

    localparam logic [1:0] ERR_PARITY = 2'b01;
    localparam logic [1:0] ERR_STOP   = 2'b10;

    localparam int PS2_DATA_BITS = 8;
    localparam int PS2_CNT_W     = $clog2(PS2_DATA_BITS);

    function automatic logic [1:0] ps2_err_code(input logic perr, input logic serr);
        return (perr ? ERR_PARITY : 2'b00) | (serr ? ERR_STOP : 2'b00);
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronisers for the PS/2 clock and data lines plus a clock falling-edge strobe.
// Flops reset high to match the idle open-collector bus.
module ps2_line_sync
    import mouse_ps2_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic ps2_clk_i,
    input  logic ps2_dat_i,
    output logic clk_sync_o,
    output logic dat_sync_o,
    output logic fall_o
);

    logic clk_s1_q, clk_s2_q, clk_s3_q;
    logic dat_s1_q, dat_s2_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            clk_s3_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk_i;
            clk_s2_q <= clk_s1_q;
            clk_s3_q <= clk_s2_q;
            dat_s1_q <= ps2_dat_i;
            dat_s2_q <= dat_s1_q;
        end
    end

    assign clk_sync_o = clk_s2_q;
    assign dat_sync_o = dat_s2_q;
    assign fall_o     = clk_s3_q & ~clk_s2_q;

endmodule

// File: rtl/mouse_receiver.sv
// PS/2 device-to-host frame receiver: start, 8 data bits LSB first, odd parity, stop.
// Optional inter-edge timeout abort is built when MOUSE_RX_TIMEOUT_EN is defined.
module mouse_receiver
    import mouse_ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    input  logic       DATA_MOUSE_IN,
    input  logic       READ_ENABLE,
    output logic [7:0] BYTE_READ,
    output logic [1:0] BYTE_ERROR_CODE,
    output logic       BYTE_READY
);

    logic fall;
    logic dat_sync;
    logic unused_clk_sync;

    ps2_line_sync u_sync (
        .clk_i      (CLK),
        .rst_i      (RESET),
        .ps2_clk_i  (CLK_MOUSE_IN),
        .ps2_dat_i  (DATA_MOUSE_IN),
        .clk_sync_o (unused_clk_sync),
        .dat_sync_o (dat_sync),
        .fall_o     (fall)
    );

    ps2_state_e               state_q, state_d;
    logic [PS2_CNT_W-1:0]     bit_cnt_q;
    logic [PS2_DATA_BITS-1:0] shift_q;
    logic [PS2_DATA_BITS-1:0] byte_q;
    logic                     perr_q;
    logic [1:0]               err_q;
    logic                     rdy_q;
    logic                     timeout;
    logic                     abort;
    logic                     done;

`ifdef MOUSE_RX_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;

    always_comb begin
        to_cnt_d = to_cnt_q;
        if (fall || state_q == PS2_IDLE) begin
            to_cnt_d = '0;
        end else if (to_cnt_q != TO_LAST) begin
            to_cnt_d = to_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            to_cnt_q <= '0;
        end else begin
            to_cnt_q <= to_cnt_d;
        end
    end

    // An edge arriving on the expiry cycle keeps the frame alive.
    assign timeout = (state_q != PS2_IDLE) && !fall && (to_cnt_q == TO_LAST);
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout            = 1'b0;
`endif

    assign abort = (state_q != PS2_IDLE) && (!READ_ENABLE || timeout);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= PS2_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = PS2_IDLE;
        end else if (fall) begin
            case (state_q)
                PS2_IDLE:   if (READ_ENABLE && !dat_sync) state_d = PS2_DATA;
                PS2_DATA:   if (bit_cnt_q == PS2_CNT_W'(PS2_DATA_BITS - 1)) state_d = PS2_PARITY;
                PS2_PARITY: state_d = PS2_STOP;
                PS2_STOP:   state_d = PS2_IDLE;
                default:    state_d = PS2_IDLE;
            endcase
        end
    end

    // Abort outranks a stop-bit edge in the same cycle.
    always_comb begin
        done            = (state_q == PS2_STOP) && fall && !abort;
        BYTE_READ       = byte_q;
        BYTE_ERROR_CODE = err_q;
        BYTE_READY      = rdy_q;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bit_cnt_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            perr_q    <= 1'b0;
            err_q     <= 2'b00;
            rdy_q     <= 1'b0;
        end else begin
            rdy_q <= done;
            if (fall && !abort) begin
                case (state_q)
                    PS2_IDLE: bit_cnt_q <= '0;
                    PS2_DATA: begin
                        shift_q[bit_cnt_q] <= dat_sync;
                        bit_cnt_q          <= bit_cnt_q + 1'b1;
                    end
                    PS2_PARITY: perr_q <= ~(^{shift_q, dat_sync});
                    PS2_STOP: begin
                        byte_q <= shift_q;
                        err_q  <= ps2_err_code(perr_q, ~dat_sync);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mouse_receiver.sv
// Directed bench for mouse_receiver with a scoreboard of expected {error, byte} per frame.
module tb_mouse_receiver;

    localparam int TO   = 200;
    localparam int HALF = 40;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic       CLK_MOUSE_IN = 1'b1;
    logic       DATA_MOUSE_IN = 1'b1;
    logic       READ_ENABLE = 1'b1;
    logic [7:0] BYTE_READ;
    logic [1:0] BYTE_ERROR_CODE;
    logic       BYTE_READY;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int expected_pulses = 0;

    logic [9:0] sb[$];
    logic [9:0] exp_ent;
    logic [7:0] prev_byte;
    logic [1:0] prev_err;
    logic       prev_rdy = 1'b0;

    always #5 CLK = ~CLK;

    mouse_receiver #(.TIMEOUT_CYCLES(TO)) dut (
        .CLK             (CLK),
        .RESET           (RESET),
        .CLK_MOUSE_IN    (CLK_MOUSE_IN),
        .DATA_MOUSE_IN   (DATA_MOUSE_IN),
        .READ_ENABLE     (READ_ENABLE),
        .BYTE_READ       (BYTE_READ),
        .BYTE_ERROR_CODE (BYTE_ERROR_CODE),
        .BYTE_READY      (BYTE_READY)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic mouse_bit(input logic b);
        DATA_MOUSE_IN = b;
        wait_cycles(HALF);
        CLK_MOUSE_IN = 1'b0;
        wait_cycles(HALF);
        CLK_MOUSE_IN = 1'b1;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] frame, input int n);
        for (int i = 0; i < n; i++) mouse_bit(frame[i]);
    endtask

    task automatic expect_frame(input logic [7:0] d, input logic [1:0] e);
        sb.push_back({e, d});
        expected_pulses++;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bits(mk_frame(d, p, s), 11);
        DATA_MOUSE_IN = 1'b1;
        wait_cycles(HALF);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 200 && sb.size() != 0; i++) wait_cycles(1);
        check(tag, sb.size(), 0);
    endtask

    // Monitor: every pulse must match the scoreboard; outputs must hold between pulses.
    always @(negedge CLK) begin
        if (RESET) begin
            prev_byte = BYTE_READ;
            prev_err  = BYTE_ERROR_CODE;
        end else if (BYTE_READY) begin
            pulses++;
            check("single_cycle_pulse", prev_rdy, 0);
            check("pulse_expected", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                exp_ent = sb.pop_front();
                check("byte_read", BYTE_READ, exp_ent[7:0]);
                check("byte_error_code", BYTE_ERROR_CODE, exp_ent[9:8]);
            end
            prev_byte = BYTE_READ;
            prev_err  = BYTE_ERROR_CODE;
        end else begin
            check("hold_byte", BYTE_READ, prev_byte);
            check("hold_err", BYTE_ERROR_CODE, prev_err);
        end
        prev_rdy = BYTE_READY;
    end

    initial begin
        logic [7:0] d;
        logic       p;
        logic       s;

        wait_cycles(5);
        RESET = 1'b0;
        wait_cycles(2);
        check("reset_byte", BYTE_READ, 8'h00);
        check("reset_err", BYTE_ERROR_CODE, 2'b00);
        check("reset_ready", BYTE_READY, 1'b0);

        expect_frame(8'hA5, 2'b00);
        send_frame(8'hA5, 1'b1, 1'b1);
        drain("drain_a5");

        expect_frame(8'h08, 2'b01);
        send_frame(8'h08, 1'b1, 1'b1);
        drain("drain_08_parity_err");

        expect_frame(8'h3C, 2'b10);
        send_frame(8'h3C, 1'b1, 1'b0);
        drain("drain_3c_stop_err");

        // A start bit of 1 must not open a frame.
        mouse_bit(1'b1);
        wait_cycles(HALF);
        check("start_one_ignored", pulses, expected_pulses);

`ifdef MOUSE_RX_TIMEOUT_EN
        send_bits(mk_frame(8'h55, 1'b1, 1'b1), 5);
        DATA_MOUSE_IN = 1'b1;
        wait_cycles(2 * TO);
        check("timeout_no_pulse", pulses, expected_pulses);
        check("timeout_hold_byte", BYTE_READ, 8'h3C);
`endif

        expect_frame(8'h3C, 2'b00);
        send_frame(8'h3C, 1'b1, 1'b1);
        drain("drain_3c_valid");

        send_bits(mk_frame(8'hFF, 1'b0, 1'b1), 4);
        READ_ENABLE = 1'b0;
        wait_cycles(100);
        check("abort_no_pulse", pulses, expected_pulses);
        check("abort_hold_byte", BYTE_READ, 8'h3C);
        READ_ENABLE = 1'b1;
        DATA_MOUSE_IN = 1'b1;
        wait_cycles(HALF);

        expect_frame(8'h81, 2'b00);
        send_frame(8'h81, 1'b1, 1'b1);
        drain("drain_81");

        for (int k = 0; k < 4; k++) begin
            d = 8'($urandom);
            p = 1'($urandom);
            s = 1'($urandom_range(0, 1));
            expect_frame(d, {~s, ~(^{d, p})});
            send_frame(d, p, s);
            drain("drain_random");
        end

        send_bits(mk_frame(8'h77, 1'b0, 1'b1), 4);
        @(posedge CLK);
        #3 RESET = 1'b1;
        #1;
        check("midreset_byte", BYTE_READ, 8'h00);
        check("midreset_err", BYTE_ERROR_CODE, 2'b00);
        check("midreset_ready", BYTE_READY, 1'b0);
        wait_cycles(3);
        RESET = 1'b0;
        DATA_MOUSE_IN = 1'b1;
        wait_cycles(HALF);

        expect_frame(8'hFA, 2'b00);
        send_frame(8'hFA, 1'b1, 1'b1);
        drain("drain_fa");

        check("total_pulses", pulses, expected_pulses);
        check("scoreboard_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
